// File: rtl/time_set_controller.sv
// ============================================================================
// time_set_controller
//
// Mode/set sequencer for an HH:MM:SS display clock.
//
// MODE steps RUN -> SET_HOURS -> SET_MINUTES -> SET_SECONDS -> RUN.
// INC adjusts the field being set. A press strobes the field once. Holding
// INC auto-repeats after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
// While a field is being set, its seven-segment digit pair blinks.
//
// Ports
//   clock       in   1  system clock, rising edge active
//   reset_n     in   1  asynchronous active-low reset
//   mode_btn_n  in   1  raw MODE pushbutton, active-low, asynchronous
//   inc_btn_n   in   1  raw INC pushbutton, active-low, asynchronous
//   run_en      out  1  1 = time counter runs, 0 = counting frozen
//   hours_m     out  1  one-cycle strobe: increment hours
//   minutes_m   out  1  one-cycle strobe: increment minutes
//   seconds_m   out  1  one-cycle strobe: increment seconds
//   blank_mask  out  6  bit i blanks digit i (1:0 sec, 3:2 min, 5:4 hours)
//   mode        out  2  0=RUN, 1=SET_HOURS, 2=SET_MINUTES, 3=SET_SECONDS
// ============================================================================
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int BLINK_PERIOD    = 12500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mode_btn_n,
    input  logic       inc_btn_n,
    output logic       run_en,
    output logic       hours_m,
    output logic       minutes_m,
    output logic       seconds_m,
    output logic [5:0] blank_mask,
    output logic [1:0] mode
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_PERIOD + 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HOURS   = 2'd1;
    localparam logic [1:0] ST_MINUTES = 2'd2;
    localparam logic [1:0] ST_SECONDS = 2'd3;

    // Button index 0 is MODE, index 1 is INC.
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_deb;
    logic [1:0]            r_press;
    logic [1:0][DB_W-1:0]  r_db_cnt;

    logic [1:0]            r_state;
    logic                  r_run_en;
    logic                  r_hours_m;
    logic                  r_minutes_m;
    logic                  r_seconds_m;

    logic                  r_held;
    logic                  r_first_done;
    logic [REP_W-1:0]      r_rep_cnt;

    logic [BLK_W-1:0]      r_blink_cnt;
    logic                  r_phase;

    logic                  w_mode_press;
    logic                  w_inc_press;
    logic                  w_inc_down;
    logic [REP_W-1:0]      w_rep_target;
    logic                  w_repeat;
    logic                  w_fire;

    // Two-flop synchronizers plus debounce. The debounced level flips only
    // after DEBOUNCE_CYCLES+1 consecutive mismatching samples; the press
    // pulse is registered at the same edge the level falls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= 2'b11;
            r_press  <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= {inc_btn_n, mode_btn_n};
            r_sync2 <= r_sync1;
            for (int b = 0; b < 2; b++) begin
                r_press[b] <= 1'b0;
                if (r_sync2[b] == r_deb[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_W'(DEBOUNCE_CYCLES)) begin
                    r_deb[b]    <= r_sync2[b];
                    r_db_cnt[b] <= '0;
                    r_press[b]  <= ~r_sync2[b];
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    assign w_mode_press = r_press[0];
    assign w_inc_press  = r_press[1];
    assign w_inc_down   = ~r_deb[1];

    // The first repeat waits the long delay; later ones use the short period.
    assign w_rep_target = r_first_done ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
    assign w_repeat     = r_held & w_inc_down & (r_rep_cnt == w_rep_target);

    // MODE has priority: an INC press or repeat landing with it is dropped.
    assign w_fire = (r_state != ST_RUN) & ~w_mode_press & (w_inc_press | w_repeat);

    // Mode sequencer; run_en is registered alongside so both change together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_run_en <= 1'b1;
        end else if (w_mode_press) begin
            case (r_state)
                ST_RUN:     begin r_state <= ST_HOURS;   r_run_en <= 1'b0; end
                ST_HOURS:   begin r_state <= ST_MINUTES; r_run_en <= 1'b0; end
                ST_MINUTES: begin r_state <= ST_SECONDS; r_run_en <= 1'b0; end
                default:    begin r_state <= ST_RUN;     r_run_en <= 1'b1; end
            endcase
        end
    end

    // Field strobes: one registered pulse routed by the current state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hours_m   <= 1'b0;
            r_minutes_m <= 1'b0;
            r_seconds_m <= 1'b0;
        end else begin
            r_hours_m   <= w_fire & (r_state == ST_HOURS);
            r_minutes_m <= w_fire & (r_state == ST_MINUTES);
            r_seconds_m <= w_fire & (r_state == ST_SECONDS);
        end
    end

    // Auto-repeat tracking. r_held arms only on a real press in a set state,
    // so INC held across a mode change stays inert until released and
    // pressed again. The counter holds cycles since the last strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_held       <= 1'b0;
            r_first_done <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_mode_press || (r_state == ST_RUN) || !w_inc_down) begin
            r_held       <= 1'b0;
            r_first_done <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_inc_press) begin
            r_held       <= 1'b1;
            r_first_done <= 1'b0;
            r_rep_cnt    <= REP_W'(1);
        end else if (w_repeat) begin
            r_first_done <= 1'b1;
            r_rep_cnt    <= REP_W'(1);
        end else if (r_held && (r_rep_cnt != REP_W'(REP_MAX))) begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
    end

    // Blink phase. It restarts visible on every mode change and every strobe,
    // so the digits stay lit while the user is adjusting them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_mode_press || w_fire || (r_state == ST_RUN)) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt >= BLK_W'(BLINK_PERIOD - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    always_comb begin
        blank_mask = 6'b000000;
        case (r_state)
            ST_HOURS:   blank_mask = {r_phase, r_phase, 4'b0000};
            ST_MINUTES: blank_mask = {2'b00, r_phase, r_phase, 2'b00};
            ST_SECONDS: blank_mask = {4'b0000, r_phase, r_phase};
            default:    blank_mask = 6'b000000;
        endcase
    end

    assign run_en    = r_run_en;
    assign mode      = r_state;
    assign hours_m   = r_hours_m;
    assign minutes_m = r_minutes_m;
    assign seconds_m = r_seconds_m;

endmodule

// File: tb/tb_time_set_controller.sv
// ============================================================================
// tb_time_set_controller
//
// Drives directed and random button activity into time_set_controller.
// Every cycle, the outputs are compared against a behavioural model.
// The model tracks raw-sample history, debounce windows, strobe timestamps
// and blink restart times, and derives the expected outputs from them.
// ============================================================================
module tb_time_set_controller;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int BP = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       mode_btn_n = 1'b1;
    logic       inc_btn_n = 1'b1;
    logic       run_en;
    logic       hours_m;
    logic       minutes_m;
    logic       seconds_m;
    logic [5:0] blank_mask;
    logic [1:0] mode;

    time_set_controller #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .BLINK_PERIOD   (BP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode_btn_n(mode_btn_n),
        .inc_btn_n (inc_btn_n),
        .run_en    (run_en),
        .hours_m   (hours_m),
        .minutes_m (minutes_m),
        .seconds_m (seconds_m),
        .blank_mask(blank_mask),
        .mode      (mode)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state: edges are numbered from 1 after each reset release.
    int edgeNum;
    int mMode;
    bit mHeld;
    int mLast;
    int mNStrobe;
    int mRestart;
    bit evMode;
    bit evInc;
    bit debMode;
    bit debInc;
    bit histMode[$];
    bit histInc[$];
    int strobeLog[$];
    int minLog[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, observed, expected, edgeNum);
        end
    endtask

    task automatic modelReset();
        edgeNum  = 0;
        mMode    = 0;
        mHeld    = 0;
        mLast    = 0;
        mNStrobe = 0;
        mRestart = 0;
        evMode   = 0;
        evInc    = 0;
        debMode  = 1;
        debInc   = 1;
        histMode.delete();
        histInc.delete();
    endtask

    // The debounced level flips at edge k when every synchronized sample seen
    // on edges k-DB..k disagrees with it. A sample seen on edge e is the raw
    // level taken two edges earlier; before that the synchronizer reads 0.
    function automatic bit windowFlips(input bit hist[$], input int k, input bit deb);
        if (k - DB < 1) return 1'b0;
        for (int e = k - DB; e <= k; e++) begin
            int j = e - 2;
            bit s = (j >= 1) ? hist[j-1] : 1'b0;
            if (s == deb) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance one clock edge, update the model, and compare all outputs.
    task automatic tick();
        bit         fire;
        int         thr;
        int         phase;
        bit         nextEvMode;
        bit         nextEvInc;
        logic [2:0] expStrobe;
        logic [5:0] expBlank;
        @(posedge clock);
        #1;
        edgeNum++;
        histMode.push_back(mode_btn_n);
        histInc.push_back(inc_btn_n);

        fire      = 1'b0;
        expStrobe = 3'b000;
        if (evMode) begin
            mMode    = (mMode + 1) % 4;
            mHeld    = 0;
            mRestart = edgeNum;
        end else if (mMode != 0) begin
            thr = (mNStrobe == 1) ? RD : RP;
            if (evInc) begin
                fire     = 1'b1;
                mHeld    = 1;
                mNStrobe = 1;
            end else if (mHeld && !debInc && (edgeNum - mLast == thr)) begin
                fire = 1'b1;
                mNStrobe++;
            end
            if (fire) begin
                mLast     = edgeNum;
                mRestart  = edgeNum;
                expStrobe = 3'b100 >> (mMode - 1);
            end
            if (debInc) mHeld = 0;
        end else begin
            mHeld = 0;
        end

        if (mMode == 0) begin
            expBlank = 6'b000000;
        end else begin
            phase    = ((edgeNum - mRestart) / BP) % 2;
            expBlank = ((phase != 0) ? 6'b000011 : 6'b000000) << (2 * (3 - mMode));
        end

        checkOutput("run_en", run_en, (mMode == 0));
        checkOutput("mode", mode, mMode[1:0]);
        checkOutput("hours_m", hours_m, expStrobe[2]);
        checkOutput("minutes_m", minutes_m, expStrobe[1]);
        checkOutput("seconds_m", seconds_m, expStrobe[0]);
        checkOutput("blank_mask", blank_mask, expBlank);
        checkOutput("strobe_onehot", ($countones({hours_m, minutes_m, seconds_m}) <= 1), 1);

        if (hours_m || minutes_m || seconds_m) strobeLog.push_back(edgeNum);
        if (minutes_m) minLog.push_back(edgeNum);

        nextEvMode = 1'b0;
        nextEvInc  = 1'b0;
        if (windowFlips(histMode, edgeNum, debMode)) begin
            debMode    = ~debMode;
            nextEvMode = (debMode == 1'b0);
        end
        if (windowFlips(histInc, edgeNum, debInc)) begin
            debInc    = ~debInc;
            nextEvInc = (debInc == 1'b0);
        end
        evMode = nextEvMode;
        evInc  = nextEvInc;
    endtask

    task automatic applyStimulus(input bit modeRaw, input bit incRaw, input int cycles);
        mode_btn_n = modeRaw;
        inc_btn_n  = incRaw;
        repeat (cycles) tick();
    endtask

    task automatic pressMode();
        applyStimulus(1'b0, inc_btn_n, 12);
        applyStimulus(1'b1, inc_btn_n, 12);
    endtask

    // Assert reset between edges, check the asynchronous response, then
    // release it mid-cycle so the next edge is model edge 1.
    task automatic doReset();
        reset_n = 1'b0;
        #2;
        checkOutput("rst_run_en", run_en, 1);
        checkOutput("rst_mode", mode, 0);
        checkOutput("rst_strobes", {hours_m, minutes_m, seconds_m}, 0);
        checkOutput("rst_blank", blank_mask, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int n;
        int e;
        int h;
        int startIdx;
        modelReset();
        #1;
        doReset();

        // Idle after reset.
        applyStimulus(1'b1, 1'b1, 100);
        checkOutput("t1_mode", mode, 0);
        checkOutput("t1_run_en", run_en, 1);
        checkOutput("t1_no_strobe", strobeLog.size(), 0);

        // MODE press latency: the state must still be RUN at N+6 and SET_HOURS at N+7.
        n = edgeNum + 1;
        applyStimulus(1'b0, 1'b1, 7);
        checkOutput("t2_mode_n6", mode, 0);
        tick();
        checkOutput("t2_edge", edgeNum, n + 7);
        checkOutput("t2_mode_n7", mode, 1);
        checkOutput("t2_run_en_n7", run_en, 0);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 12);
        pressMode();
        checkOutput("t2_mode2", mode, 2);
        pressMode();
        checkOutput("t2_mode3", mode, 3);
        pressMode();
        checkOutput("t2_mode0", mode, 0);
        checkOutput("t2_run_en_back", run_en, 1);

        // Auto-repeat in SET_MINUTES. The raw hold of 45 cycles makes the
        // debounced release land before a repeat would be due at N+52.
        pressMode();
        pressMode();
        checkOutput("t3_in_minutes", mode, 2);
        minLog.delete();
        n = edgeNum + 1;
        applyStimulus(1'b1, 1'b0, 45);
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("t3_count", minLog.size(), 6);
        if (minLog.size() == 6) begin
            checkOutput("t3_s0", minLog[0] - n, 7);
            checkOutput("t3_s1", minLog[1] - n, 27);
            checkOutput("t3_s2", minLog[2] - n, 32);
            checkOutput("t3_s3", minLog[3] - n, 37);
            checkOutput("t3_s4", minLog[4] - n, 42);
            checkOutput("t3_s5", minLog[5] - n, 47);
        end

        // Bounce rejection: toggling every 3 cycles, then a clean hold.
        startIdx = strobeLog.size();
        for (int i = 0; i < 40; i++) begin
            inc_btn_n = ((i / 3) % 2) != 0;
            tick();
        end
        h = edgeNum + 1;
        applyStimulus(1'b1, 1'b0, 15);
        applyStimulus(1'b1, 1'b1, 15);
        checkOutput("t4_count", strobeLog.size() - startIdx, 1);
        if (strobeLog.size() - startIdx == 1) checkOutput("t4_edge", strobeLog[startIdx] - h, 7);

        // MODE beats INC when both are pressed together in SET_HOURS.
        pressMode();
        pressMode();
        pressMode();
        checkOutput("t5_in_hours", mode, 1);
        startIdx = strobeLog.size();
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("t5_mode", mode, 2);
        checkOutput("t5_no_strobe", strobeLog.size() - startIdx, 0);
        applyStimulus(1'b1, 1'b1, 15);

        // Blink in SET_SECONDS, then reset while INC is held.
        n = edgeNum + 1;
        e = n + 7;
        for (int i = 0; i < 40; i++) begin
            mode_btn_n = (i < 12) ? 1'b0 : 1'b1;
            tick();
            if (edgeNum == e + 4)  checkOutput("t6_blank_a", blank_mask, 6'b000000);
            if (edgeNum == e + 12) checkOutput("t6_blank_b", blank_mask, 6'b000011);
            if (edgeNum == e + 20) checkOutput("t6_blank_c", blank_mask, 6'b000000);
            if (edgeNum == e + 28) checkOutput("t6_blank_d", blank_mask, 6'b000011);
        end
        checkOutput("t6_mode", mode, 3);
        applyStimulus(1'b1, 1'b0, 30);
        checkOutput("t6_mode_before_rst", mode, 3);
        doReset();
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 20);

        // Random button activity, checked cycle by cycle against the model.
        while (edgeNum < 1500) begin
            mode_btn_n = ($urandom_range(0, 3) != 0);
            inc_btn_n  = ($urandom_range(0, 1) != 0);
            repeat ($urandom_range(1, 35)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
